unidade_controle_turnos: RTL and testbench
==========================================

// Module: unidade_controle_turnos
// PURPOSE
//  Parametrised turn controller for the macro/micro board game. Each turn it
//  collects a macro move and a micro move, with a validation retry for each.
//  It skips the macro move when the board is already forced, asks the datapath
//  to check for end of game, rotates players and enforces a per-turn timeout.
//  Sits between the edge-detected button logic and the board/register datapath.
// PARAMETERS
//  N_JOGADORES  2     players in rotation (>=2); JW=$clog2(N_JOGADORES) localparam
//  TIMEOUT      1000  clock cycles allowed per turn in JOGA states; 0 disables
//  TW           10    timeout counter width; requires TIMEOUT < 2**TW
// PORTS
//  clock            in   1   system clock, all logic on rising edge
//  reset            in   1   synchronous, active-high
//  iniciar          in   1   start / restart game (level, sampled in INICIAL/FIM/FIM_TO)
//  tem_jogada       in   1   one-cycle pulse: a move is presented
//  jogada_valida    in   1   datapath verdict on just-registered move (VALIDA states)
//  macro_forcado    in   1   next macro board fixed and playable (sampled in TROCA)
//  fim_jogo         in   1   win/draw detected by datapath (sampled in VERIFICA)
//  zeraR_macro      out  1   clear macro register
//  zeraR_micro      out  1   clear micro register
//  zeraEdge         out  1   clear edge detector
//  registraR_macro  out  1   load macro register
//  registraR_micro  out  1   load micro register
//  jogar_macro      out  1   waiting for macro move
//  jogar_micro      out  1   waiting for micro move
//  verifica         out  1   request end-of-game check
//  jogador_atual    out  JW  player on move, registered
//  pronto           out  1   game over (normal or timeout)
//  timeout          out  1   game ended by timeout; jogador_atual = loser
//  db_estado        out  4   current state code
// BEHAVIOUR
//  - Moore FSM; every output except jogador_atual is decoded from state only.
//  - States: INICIAL=0 PREPARA=1 JOGA_MACRO=2 REGISTRA_MACRO=3 VALIDA_MACRO=4
//    JOGA_MICRO=5 REGISTRA_MICRO=6 VALIDA_MICRO=7 VERIFICA=8 TROCA=9 FIM=10
//    FIM_TO=11. Codes 12-15 -> INICIAL next cycle, db_estado=0.
//  - INICIAL: iniciar ? PREPARA : INICIAL. zeraR_macro/zeraR_micro/zeraEdge=1.
//  - PREPARA: same three clears =1. jogador_atual<=0, timer<=0 -> JOGA_MACRO.
//  - JOGA_MACRO/JOGA_MICRO: tem_jogada -> REGISTRA_x; else timer expiry -> FIM_TO.
//    tem_jogada wins over expiry in the same cycle.
//  - REGISTRA_x: registraR_x=1 for one cycle -> VALIDA_x.
//  - VALIDA_MACRO: jogada_valida ? JOGA_MICRO : JOGA_MACRO.
//  - VALIDA_MICRO: jogada_valida ? VERIFICA : JOGA_MICRO.
//  - VERIFICA: verifica=1; fim_jogo ? FIM : TROCA.
//  - TROCA: jogador_atual <= (jogador_atual==N_JOGADORES-1) ? 0 : +1.
//    Timer <= 0. Next state: macro_forcado ? JOGA_MICRO : JOGA_MACRO.
//  - FIM: pronto=1. FIM_TO: pronto=1, timeout=1. Both: iniciar -> PREPARA.
//    jogador_atual held in both.
//  - Timer: +1 each cycle in a JOGA state, held elsewhere.
//    Cleared only in PREPARA/TROCA, so it is a per-turn budget; invalid-move
//    retries do not refill it.
//  - Expiry: timer==TIMEOUT-1 in a JOGA state. Exactly TIMEOUT JOGA cycles
//    without a move reach FIM_TO. TIMEOUT=0: never expires.
//  - Latency: tem_jogada in JOGA_x -> registraR_x asserted next cycle.
//  - Reset (any state, mid-turn included) -> next edge: INICIAL.
//    jogador_atual=0, timer=0, all strobes 0, zero-clears=1, db_estado=0.
//    Reset has priority over every input.
// TESTING
//  1 reset; iniciar=1 1cy; tem_jogada at JOGA_MACRO, valid=1 both; fim_jogo=0,
//    macro_forcado=0 -> states 0,1,2,3,4,5,6,7,8,9,2; jogador_atual 0->1.
//  2 invalid macro then valid: jogada_valida=0 in VALIDA_MACRO -> back to 2,
//    timer not cleared; second move proceeds to 5.
//  3 macro_forcado=1 at TROCA -> 9->5 directly; jogar_macro never asserted.
//  4 TIMEOUT=8, no tem_jogada -> FIM_TO after exactly 8 cycles in state 2.
//    pronto=1, timeout=1. Also: tem_jogada on 8th cycle -> state 3, no timeout.
//  5 N_JOGADORES=3: three full turns -> jogador_atual 0,1,2,0.
//    fim_jogo=1 in VERIFICA -> FIM, pronto=1. iniciar -> PREPARA, jogador 0.
//  6 reset asserted in JOGA_MICRO with jogador_atual=1 -> next cycle state 0.
//    jogador_atual=0, zeraR_macro=zeraR_micro=zeraEdge=1.

Source files
------------

// File: rtl/unidade_controle_turnos_if.sv
// Turn controller bundle: start/move/verdict inputs,
// register strobes, turn status and debug state code.
interface unidade_controle_turnos_if #(
  parameter int JW = 1
);
  logic          iniciar;
  logic          tem_jogada;
  logic          jogada_valida;
  logic          macro_forcado;
  logic          fim_jogo;
  logic          zeraR_macro;
  logic          zeraR_micro;
  logic          zeraEdge;
  logic          registraR_macro;
  logic          registraR_micro;
  logic          jogar_macro;
  logic          jogar_micro;
  logic          verifica;
  logic [JW-1:0] jogador_atual;
  logic          pronto;
  logic          timeout;
  logic [3:0]    db_estado;

  modport master (
    output iniciar, tem_jogada, jogada_valida,
    output macro_forcado, fim_jogo,
    input  zeraR_macro, zeraR_micro, zeraEdge,
    input  registraR_macro, registraR_micro,
    input  jogar_macro, jogar_micro, verifica,
    input  jogador_atual, pronto, timeout, db_estado
  );

  modport slave (
    input  iniciar, tem_jogada, jogada_valida,
    input  macro_forcado, fim_jogo,
    output zeraR_macro, zeraR_micro, zeraEdge,
    output registraR_macro, registraR_micro,
    output jogar_macro, jogar_micro, verifica,
    output jogador_atual, pronto, timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_turnos.sv
// Macro/micro board game turn controller: move capture
// with retries, forced-macro skip, player rotation, turn timeout.
module unidade_controle_turnos #(
  parameter int N_JOGADORES = 2,
  parameter int TIMEOUT     = 1000,
  parameter int TW          = 10
) (
  input logic                      clock,
  input logic                      reset,
  unidade_controle_turnos_if.slave bus
);
  localparam int JW =
    (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1;
  localparam logic [TW-1:0] LIM =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [JW-1:0] ULT = JW'(N_JOGADORES - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    JOGA_MACRO     = 4'd2,
    REGISTRA_MACRO = 4'd3,
    VALIDA_MACRO   = 4'd4,
    JOGA_MICRO     = 4'd5,
    REGISTRA_MICRO = 4'd6,
    VALIDA_MICRO   = 4'd7,
    VERIFICA       = 4'd8,
    TROCA          = 4'd9,
    FIM            = 4'd10,
    FIM_TO         = 4'd11
  } estado_t;

  estado_t       r_estado;
  estado_t       w_prox;
  logic [TW-1:0] r_timer;
  logic [JW-1:0] r_jogador;
  logic          w_joga;
  logic          w_expira;
  logic [3:0]    w_cod;

  assign w_joga = (r_estado == JOGA_MACRO) ||
                  (r_estado == JOGA_MICRO);
  assign w_expira = (TIMEOUT != 0) && w_joga &&
                    (r_timer == LIM);
  assign w_cod = r_estado;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_estado <= INICIAL;
    else       r_estado <= w_prox;
  end

  // Per-turn budget and player rotation
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer   <= '0;
      r_jogador <= '0;
    end else if (r_estado == PREPARA) begin
      r_timer   <= '0;
      r_jogador <= '0;
    end else if (r_estado == TROCA) begin
      r_timer   <= '0;
      r_jogador <= (r_jogador == ULT) ? '0 :
                   r_jogador + 1'b1;
    end else if (w_joga) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Next-state logic; a move beats expiry
  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      INICIAL:
        if (bus.iniciar) w_prox = PREPARA;
      PREPARA:
        w_prox = JOGA_MACRO;
      JOGA_MACRO:
        if (bus.tem_jogada) w_prox = REGISTRA_MACRO;
        else if (w_expira)  w_prox = FIM_TO;
      REGISTRA_MACRO:
        w_prox = VALIDA_MACRO;
      VALIDA_MACRO:
        w_prox = bus.jogada_valida ? JOGA_MICRO :
                                     JOGA_MACRO;
      JOGA_MICRO:
        if (bus.tem_jogada) w_prox = REGISTRA_MICRO;
        else if (w_expira)  w_prox = FIM_TO;
      REGISTRA_MICRO:
        w_prox = VALIDA_MICRO;
      VALIDA_MICRO:
        w_prox = bus.jogada_valida ? VERIFICA :
                                     JOGA_MICRO;
      VERIFICA:
        w_prox = bus.fim_jogo ? FIM : TROCA;
      TROCA:
        w_prox = bus.macro_forcado ? JOGA_MICRO :
                                     JOGA_MACRO;
      FIM, FIM_TO:
        if (bus.iniciar) w_prox = PREPARA;
      default:
        w_prox = INICIAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    bus.zeraR_macro     = 1'b0;
    bus.zeraR_micro     = 1'b0;
    bus.zeraEdge        = 1'b0;
    bus.registraR_macro = 1'b0;
    bus.registraR_micro = 1'b0;
    bus.jogar_macro     = 1'b0;
    bus.jogar_micro     = 1'b0;
    bus.verifica        = 1'b0;
    bus.pronto          = 1'b0;
    bus.timeout         = 1'b0;
    unique case (1'b1)
      (r_estado == INICIAL),
      (r_estado == PREPARA): begin
        bus.zeraR_macro = 1'b1;
        bus.zeraR_micro = 1'b1;
        bus.zeraEdge    = 1'b1;
      end
      (r_estado == REGISTRA_MACRO):
        bus.registraR_macro = 1'b1;
      (r_estado == REGISTRA_MICRO):
        bus.registraR_micro = 1'b1;
      (r_estado == JOGA_MACRO):
        bus.jogar_macro = 1'b1;
      (r_estado == JOGA_MICRO):
        bus.jogar_micro = 1'b1;
      (r_estado == VERIFICA):
        bus.verifica = 1'b1;
      (r_estado == FIM):
        bus.pronto = 1'b1;
      (r_estado == FIM_TO): begin
        bus.pronto  = 1'b1;
        bus.timeout = 1'b1;
      end
      default: ;
    endcase
  end

  // Debug code and registered player
  always_comb begin
    bus.db_estado = (w_cod < 4'd12) ? w_cod : 4'd0;
    bus.jogador_atual = r_jogador;
  end
endmodule

// File: tb/tb_unidade_controle_turnos.sv
// Turn controller bench: directed scenarios plus
// random stimulus against a behavioural game model.
module tb_unidade_controle_turnos;
  localparam int NJ = 3;
  localparam int TO = 8;
  localparam int JW = 2;
  localparam int TM = 16;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  unidade_controle_turnos_if #(.JW(JW)) bus();

  unidade_controle_turnos #(
    .N_JOGADORES(NJ),
    .TIMEOUT(TO),
    .TW(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.iniciar       = 1'b0;
    bus.tem_jogada    = 1'b0;
    bus.jogada_valida = 1'b1;
    bus.macro_forcado = 1'b0;
    bus.fim_jogo      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start();
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tick();
  endtask

  task automatic move(input bit v);
    bus.jogada_valida = v;
    bus.tem_jogada = 1'b1;
    tick();
    bus.tem_jogada = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] s;
    idle();
    reset = 1'b1;
    tick();
    s = {bus.registraR_macro, bus.registraR_micro,
         bus.jogar_macro, bus.jogar_micro,
         bus.verifica, bus.pronto, bus.timeout};
    n_tests++;
    if (bus.db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0",
               bus.db_estado);
    end
    n_tests++;
    if (bus.jogador_atual !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_player: got %0d want 0",
               bus.jogador_atual);
    end
    n_tests++;
    if ({bus.zeraR_macro, bus.zeraR_micro,
         bus.zeraEdge} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_clears: got %b want 111",
               {bus.zeraR_macro, bus.zeraR_micro,
                bus.zeraEdge});
    end
    n_tests++;
    if (s !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0", s);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (bus.db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got %0d want 0",
               bus.db_estado);
    end
  endtask

  task automatic test_turn();
    int exp_s[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 2};
    bit tem_s[10] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    idle();
    for (int k = 0; k < 10; k++) begin
      bus.iniciar    = (k == 0);
      bus.tem_jogada = tem_s[k];
      tick();
      n_tests++;
      if (bus.db_estado !== 4'(exp_s[k])) begin
        n_fail++;
        $display("FAIL turn_seq[%0d]: got %0d want %0d",
                 k, bus.db_estado, exp_s[k]);
      end
      if (exp_s[k] == 3) begin
        n_tests++;
        if (bus.registraR_macro !== 1'b1) begin
          n_fail++;
          $display("FAIL reg_latency: got %b want 1",
                   bus.registraR_macro);
        end
      end
      if (exp_s[k] == 9) begin
        n_tests++;
        if (bus.jogador_atual !== 2'd0) begin
          n_fail++;
          $display("FAIL troca_player: got %0d want 0",
                   bus.jogador_atual);
        end
      end
    end
    bus.tem_jogada = 1'b0;
    n_tests++;
    if (bus.jogador_atual !== 2'd1) begin
      n_fail++;
      $display("FAIL rotate_player: got %0d want 1",
               bus.jogador_atual);
    end
  endtask

  task automatic test_invalid();
    move(1'b0);
    n_tests++;
    if (bus.db_estado !== 4'd2) begin
      n_fail++;
      $display("FAIL invalid_macro: got %0d want 2",
               bus.db_estado);
    end
    move(1'b1);
    n_tests++;
    if (bus.db_estado !== 4'd5) begin
      n_fail++;
      $display("FAIL retry_macro: got %0d want 5",
               bus.db_estado);
    end
    move(1'b0);
    n_tests++;
    if (bus.db_estado !== 4'd5) begin
      n_fail++;
      $display("FAIL invalid_micro: got %0d want 5",
               bus.db_estado);
    end
    move(1'b1);
    n_tests++;
    if (bus.verifica !== 1'b1 || bus.db_estado !== 4'd8) begin
      n_fail++;
      $display("FAIL verifica: got %0d/%b want 8/1",
               bus.db_estado, bus.verifica);
    end
  endtask

  task automatic test_forced();
    bus.fim_jogo = 1'b0;
    tick();
    n_tests++;
    if (bus.db_estado !== 4'd9 || bus.jogar_macro !== 1'b0) begin
      n_fail++;
      $display("FAIL forced_troca: got %0d/%b want 9/0",
               bus.db_estado, bus.jogar_macro);
    end
    bus.macro_forcado = 1'b1;
    tick();
    bus.macro_forcado = 1'b0;
    n_tests++;
    if (bus.db_estado !== 4'd5 || bus.jogar_macro !== 1'b0 ||
        bus.jogar_micro !== 1'b1) begin
      n_fail++;
      $display("FAIL forced_skip: got %0d/%b%b want 5/01",
               bus.db_estado, bus.jogar_macro,
               bus.jogar_micro);
    end
    n_tests++;
    if (bus.jogador_atual !== 2'd2) begin
      n_fail++;
      $display("FAIL forced_player: got %0d want 2",
               bus.jogador_atual);
    end
  endtask

  task automatic test_timeout();
    int bad;
    idle();
    do_reset();
    start();
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.db_estado !== 4'd2) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL early_expiry: got %0d bad want 0", bad);
    end
    tick();
    n_tests++;
    if (bus.db_estado !== 4'd11 || bus.pronto !== 1'b1 ||
        bus.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL expiry: got %0d/%b%b want 11/11",
               bus.db_estado, bus.pronto, bus.timeout);
    end
    start();
    for (int i = 0; i < 7; i++) tick();
    bus.tem_jogada = 1'b1;
    tick();
    bus.tem_jogada = 1'b0;
    n_tests++;
    if (bus.db_estado !== 4'd3 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL move_wins: got %0d/%b want 3/0",
               bus.db_estado, bus.timeout);
    end
    do_reset();
    start();
    move(1'b0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.db_estado !== 4'd2) bad++;
    end
    tick();
    n_tests++;
    if (bad != 0 || bus.db_estado !== 4'd11) begin
      n_fail++;
      $display("FAIL retry_budget: got %0d/%0d want 0/11",
               bad, bus.db_estado);
    end
  endtask

  task automatic test_players();
    idle();
    do_reset();
    start();
    for (int t = 0; t < 4; t++) begin
      move(1'b1);
      move(1'b1);
      tick();
      tick();
      n_tests++;
      if (bus.jogador_atual !== 2'((t + 1) % NJ)) begin
        n_fail++;
        $display("FAIL rotation[%0d]: got %0d want %0d",
                 t, bus.jogador_atual, (t + 1) % NJ);
      end
    end
    move(1'b1);
    move(1'b1);
    bus.fim_jogo = 1'b1;
    tick();
    bus.fim_jogo = 1'b0;
    tick();
    n_tests++;
    if (bus.db_estado !== 4'd10 || bus.pronto !== 1'b1 ||
        bus.timeout !== 1'b0 ||
        bus.jogador_atual !== 2'd1) begin
      n_fail++;
      $display("FAIL fim: got %0d/%b%b/%0d want 10/10/1",
               bus.db_estado, bus.pronto, bus.timeout,
               bus.jogador_atual);
    end
    start();
    n_tests++;
    if (bus.db_estado !== 4'd2 ||
        bus.jogador_atual !== 2'd0) begin
      n_fail++;
      $display("FAIL restart: got %0d/%0d want 2/0",
               bus.db_estado, bus.jogador_atual);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    do_reset();
    start();
    move(1'b1);
    move(1'b1);
    tick();
    tick();
    move(1'b1);
    n_tests++;
    if (bus.db_estado !== 4'd5 ||
        bus.jogador_atual !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_setup: got %0d/%0d want 5/1",
               bus.db_estado, bus.jogador_atual);
    end
    bus.tem_jogada = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.tem_jogada = 1'b0;
    n_tests++;
    if (bus.db_estado !== 4'd0 ||
        bus.jogador_atual !== 2'd0 ||
        {bus.zeraR_macro, bus.zeraR_micro,
         bus.zeraEdge} !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_reset: got %0d/%0d/%b want 0/0/111",
               bus.db_estado, bus.jogador_atual,
               {bus.zeraR_macro, bus.zeraR_micro,
                bus.zeraEdge});
    end
  endtask

  int ms, mp, mu;

  task automatic model_step(
    input bit rst, input bit ini, input bit tem,
    input bit val, input bit forc, input bit fim
  );
    int  nxt;
    bit  joga;
    if (rst) begin
      ms = 0;
      mp = 0;
      mu = 0;
      return;
    end
    joga = (ms == 2) || (ms == 5);
    nxt = ms;
    case (ms)
      0: if (ini) nxt = 1;
      1: begin
        nxt = 2;
        mp  = 0;
        mu  = 0;
      end
      2, 5: begin
        if (tem)              nxt = ms + 1;
        else if (mu == TO - 1) nxt = 11;
      end
      3, 6: nxt = ms + 1;
      4: nxt = val ? 5 : 2;
      7: nxt = val ? 8 : 5;
      8: nxt = fim ? 10 : 9;
      9: begin
        mp  = (mp + 1) % NJ;
        mu  = 0;
        nxt = forc ? 5 : 2;
      end
      10, 11: if (ini) nxt = 1;
      default: nxt = 0;
    endcase
    if (joga) mu = (mu + 1) % TM;
    ms = nxt;
  endtask

  task automatic test_random();
    bit r, a, b, c, d, e;
    logic [15:0] ev, ov;
    for (int k = 0; k < 3000; k++) begin
      r = (k == 0) || ($urandom_range(0, 299) == 0);
      a = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 2) != 0);
      d = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 5) == 0);
      reset             = r;
      bus.iniciar       = a;
      bus.tem_jogada    = b;
      bus.jogada_valida = c;
      bus.macro_forcado = d;
      bus.fim_jogo      = e;
      @(posedge clock);
      model_step(r, a, b, c, d, e);
      #1;
      ev = {4'(ms), 2'(mp), {3{ms <= 1}},
            ms == 3, ms == 6, ms == 2, ms == 5,
            ms == 8, ms >= 10, ms == 11};
      ov = {bus.db_estado, bus.jogador_atual,
            bus.zeraR_macro, bus.zeraR_micro,
            bus.zeraEdge, bus.registraR_macro,
            bus.registraR_micro, bus.jogar_macro,
            bus.jogar_micro, bus.verifica,
            bus.pronto, bus.timeout};
      n_tests++;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h",
                 k, ov, ev);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_turn();
    test_invalid();
    test_forced();
    test_timeout();
    test_players();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
